// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add/subtract sequencer.
// Drives a shared 8-bit adder one byte per cycle (LS byte first), chaining the
// carry through a register, and assembles an NBYTES-wide result with C/V/Z flags.
//
// Optional feature: define MP_ADD_SAT_EN to saturate the result on signed
// overflow (0x7F..FF for positive A, 0x80..00 for negative A).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, sub, cin_in   request (sampled in IDLE), subtract select, carry/borrow in
//   op_a, op_b           operands, latched with start
//   add_a, add_b, add_cin  drive to adder IA/IB/cin
//   add_s, add_cout, add_vout  return from adder IS/cout/vout
//   busy, done           busy while running; one-cycle completion pulse
//   result               registered NBYTES-wide result
//   c_flag, v_flag, z_flag  carry/borrow, signed overflow, zero
module mp_add_seq #(
   parameter int unsigned NBYTES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                sub,
   input  logic                cin_in,
   input  logic [8*NBYTES-1:0] op_a,
   input  logic [8*NBYTES-1:0] op_b,
   output logic [7:0]          add_a,
   output logic [7:0]          add_b,
   output logic                add_cin,
   input  logic [7:0]          add_s,
   input  logic                add_cout,
   input  logic                add_vout,
   output logic                busy,
   output logic                done,
   output logic [8*NBYTES-1:0] result,
   output logic                c_flag,
   output logic                v_flag,
   output logic                z_flag
);

   localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LastIdx = IW'(NBYTES - 1);

`ifdef MP_ADD_SAT_EN
   localparam logic [8*NBYTES-1:0] SatPos = {1'b0, {(8*NBYTES-1){1'b1}}};
   localparam logic [8*NBYTES-1:0] SatNeg = {1'b1, {(8*NBYTES-1){1'b0}}};
`endif

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                   state_q;
   logic [IW-1:0]            idx_q;
   logic                     carry_q;
   logic                     sub_q;
   logic                     zacc_q;
   logic [NBYTES-1:0][7:0]   a_q;
   logic [NBYTES-1:0][7:0]   b_q;      // B, already inverted for subtract
   logic [NBYTES-1:0][7:0]   result_q;
   logic                     c_q;
   logic                     v_q;
   logic                     z_q;
   logic                     busy_q;
   logic                     done_q;

   // Adder drive is combinational from the current byte so the adder result
   // is ready to be captured at the next edge.
   always_comb begin
      add_a   = 8'h00;
      add_b   = 8'h00;
      add_cin = 1'b0;
      if (state_q == StRun) begin
         add_a   = a_q[idx_q];
         add_b   = b_q[idx_q];
         add_cin = carry_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         sub_q    <= 1'b0;
         zacc_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
         z_q      <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  a_q     <= op_a;
                  b_q     <= sub ? ~op_b : op_b;
                  sub_q   <= sub;
                  // Subtract is A + ~B + ~borrow_in.
                  carry_q <= cin_in ^ sub;
                  idx_q   <= '0;
                  zacc_q  <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               result_q[idx_q] <= add_s;
               carry_q         <= add_cout;
               zacc_q          <= zacc_q & (add_s == 8'h00);
               idx_q           <= idx_q + 1'b1;
               if (idx_q == LastIdx) begin
                  // Adder cout of A + ~B is the inverse of borrow.
                  c_q     <= add_cout ^ sub_q;
                  v_q     <= add_vout;
                  z_q     <= zacc_q & (add_s == 8'h00);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StDone;
`ifdef MP_ADD_SAT_EN
                  if (add_vout) begin
                     result_q <= a_q[NBYTES-1][7] ? SatNeg : SatPos;
                     z_q      <= 1'b0;
                  end
`endif
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign c_flag = c_q;
   assign v_flag = v_q;
   assign z_flag = z_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq: three instances (NBYTES = 1, 2, 4) each paired with a
// behavioural 8-bit adder, driven with directed and random operations and
// checked against a full-width arithmetic reference model.
module tb_mp_add_seq;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        start1, start2, start4, sub, cin_in;
   logic [31:0] op_a, op_b;

   logic [7:0]  aa1, ab1, as1, res1;
   logic        ac1, co1, vo1, busy1, done1, c1, v1, z1;
   logic [7:0]  aa2, ab2, as2;
   logic [15:0] res2;
   logic        ac2, co2, vo2, busy2, done2, c2, v2, z2;
   logic [7:0]  aa4, ab4, as4;
   logic [31:0] res4;
   logic        ac4, co4, vo4, busy4, done4, c4, v4, z4;

   // Behavioural 8-bit adders
   assign {co1, as1} = 9'(aa1) + 9'(ab1) + 9'(ac1);
   assign vo1 = (aa1[7] == ab1[7]) && (as1[7] != aa1[7]);
   assign {co2, as2} = 9'(aa2) + 9'(ab2) + 9'(ac2);
   assign vo2 = (aa2[7] == ab2[7]) && (as2[7] != aa2[7]);
   assign {co4, as4} = 9'(aa4) + 9'(ab4) + 9'(ac4);
   assign vo4 = (aa4[7] == ab4[7]) && (as4[7] != aa4[7]);

   mp_add_seq #(.NBYTES(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub), .cin_in(cin_in),
      .op_a(op_a[7:0]), .op_b(op_b[7:0]), .add_a(aa1), .add_b(ab1), .add_cin(ac1),
      .add_s(as1), .add_cout(co1), .add_vout(vo1), .busy(busy1), .done(done1),
      .result(res1), .c_flag(c1), .v_flag(v1), .z_flag(z1)
   );
   mp_add_seq #(.NBYTES(2)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub), .cin_in(cin_in),
      .op_a(op_a[15:0]), .op_b(op_b[15:0]), .add_a(aa2), .add_b(ab2), .add_cin(ac2),
      .add_s(as2), .add_cout(co2), .add_vout(vo2), .busy(busy2), .done(done2),
      .result(res2), .c_flag(c2), .v_flag(v2), .z_flag(z2)
   );
   mp_add_seq #(.NBYTES(4)) u4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub), .cin_in(cin_in),
      .op_a(op_a), .op_b(op_b), .add_a(aa4), .add_b(ab4), .add_cin(ac4),
      .add_s(as4), .add_cout(co4), .add_vout(vo4), .busy(busy4), .done(done4),
      .result(res4), .c_flag(c4), .v_flag(v4), .z_flag(z4)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer arithmetic on n-byte operands.
   function automatic void model(input int n, input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input logic ci, output logic [31:0] r,
                                 output logic c, output logic v, output logic z);
      longint m, h, ua, ub, sa, sb, u, ex;
      m  = longint'(1) << (8 * n);
      h  = m / 2;
      ua = longint'(a) & (m - 1);
      ub = longint'(b) & (m - 1);
      sa = (ua >= h) ? ua - m : ua;
      sb = (ub >= h) ? ub - m : ub;
      if (!s) begin
         u  = ua + ub + longint'(ci);
         ex = sa + sb + longint'(ci);
         c  = (u >= m);
      end else begin
         u  = ua - ub - longint'(ci);
         ex = sa - sb - longint'(ci);
         c  = (u < 0);
      end
      v = (ex < -h) || (ex >= h);
      u = u & (m - 1);
`ifdef MP_ADD_SAT_EN
      if (v) u = (sa < 0) ? h : h - 1;
`endif
      r = 32'(u);
      z = (u == 0);
   endfunction

   task automatic chk_unit(input int n, input int cyc, input logic dn, input logic bz,
                           input logic [31:0] res, input logic c, input logic v,
                           input logic z, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic ci);
      logic [31:0] er;
      logic        ec, ev, ez;
      string       t;
      t = $sformatf("n%0d_cyc%0d", n, cyc);
      model(n, a, b, s, ci, er, ec, ev, ez);
      chk({t, "_busy"}, 32'(bz), 32'(cyc < n));
      chk({t, "_done"}, 32'(dn), 32'(cyc == n));
      if (cyc >= n) begin
         chk({t, "_result"}, res, er);
         chk({t, "_c"}, 32'(c), 32'(ec));
         chk({t, "_v"}, 32'(v), 32'(ev));
         chk({t, "_z"}, 32'(z), 32'(ez));
      end
   endtask

   // Adder input for byte i of the 2-byte unit, derived from partial sums.
   task automatic chk_bus(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic ci);
      logic [31:0] bb;
      longint      ua, ub, c0, lo, cy;
      bb = s ? ~b : b;
      ua = longint'(a) & 64'hFFFF;
      ub = longint'(bb) & 64'hFFFF;
      c0 = longint'(s ^ ci);
      lo = (longint'(1) << (8 * i)) - 1;
      cy = ((ua & lo) + (ub & lo) + c0) >> (8 * i);
      chk($sformatf("bus%0d_a", i), 32'(aa2), 32'((ua >> (8 * i)) & 255));
      chk($sformatf("bus%0d_b", i), 32'(ab2), 32'((ub >> (8 * i)) & 255));
      chk($sformatf("bus%0d_cin", i), 32'(ac2), 32'(cy & 1));
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic ci);
      op_a = a; op_b = b; sub = s; cin_in = ci;
      start1 = 1'b1; start2 = 1'b1; start4 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0; start2 = 1'b0; start4 = 1'b0;
      // Scramble inputs: the units must work from latched operands.
      op_a = $urandom; op_b = $urandom;
      sub = 1'($urandom_range(0, 1)); cin_in = 1'($urandom_range(0, 1));
      for (int cyc = 0; cyc <= 5; cyc++) begin
         if (cyc > 0) begin
            @(posedge clk); #1;
         end
         chk_unit(1, cyc, done1, busy1, {24'h0, res1}, c1, v1, z1, a, b, s, ci);
         chk_unit(2, cyc, done2, busy2, {16'h0, res2}, c2, v2, z2, a, b, s, ci);
         chk_unit(4, cyc, done4, busy4, res4, c4, v4, z4, a, b, s, ci);
         if (cyc < 2) chk_bus(cyc, a, b, s, ci);
      end
   endtask

   task automatic chk_all_zero(input string t);
      chk({t, "_res1"}, {24'h0, res1}, 32'h0);
      chk({t, "_res2"}, {16'h0, res2}, 32'h0);
      chk({t, "_res4"}, res4, 32'h0);
      chk({t, "_flags"}, {29'h0, c1 | c2 | c4, v1 | v2 | v4, z1 | z2 | z4}, 32'h0);
      chk({t, "_busy"}, {29'h0, busy1, busy2, busy4}, 32'h0);
      chk({t, "_done"}, {29'h0, done1, done2, done4}, 32'h0);
      chk({t, "_bus2"}, {15'h0, ac2, aa2, ab2}, 32'h0);
      chk({t, "_bus4"}, {15'h0, ac4, aa4, ab4}, 32'h0);
   endtask

   logic [31:0] da [9] = '{32'h00FF, 32'hFFFF, 32'h7FFF, 32'h0100, 32'h0000, 32'h8000,
                           32'h0000007F, 32'hFFFFFFFF, 32'h12345678};
   logic [31:0] db [9] = '{32'h0001, 32'h0001, 32'h0001, 32'h0001, 32'h0001, 32'h0001,
                           32'h00000001, 32'h00000000, 32'h9ABCDEF0};
   logic        ds [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   logic        dc [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] er, ra, rb;
      logic        ec, ev, ez, rs, rc;

      rst_n = 1'b0;
      start1 = 1'b0; start2 = 1'b0; start4 = 1'b0;
      sub = 1'b0; cin_in = 1'b0; op_a = '0; op_b = '0;
      #2;
      chk_all_zero("reset");
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // Directed operations from the plan
      for (int i = 0; i < 9; i++) run_op(da[i], db[i], ds[i], dc[i]);

      // start during RUN and DONE is ignored; back-to-back from IDLE works
      op_a = 32'h1234; op_b = 32'h0FF1; sub = 1'b0; cin_in = 1'b0; start2 = 1'b1;
      @(posedge clk); #1;
      chk("ign_busy0", 32'(busy2), 32'd1);
      op_a = 32'h8001; op_b = 32'h0002; sub = 1'b1; cin_in = 1'b1;
      @(posedge clk); #1;
      chk("ign_done1", 32'(done2), 32'd0);
      @(posedge clk); #1;
      model(2, 32'h1234, 32'h0FF1, 1'b0, 1'b0, er, ec, ev, ez);
      chk("ign_done2", 32'(done2), 32'd1);
      chk("ign_res", {16'h0, res2}, er);
      chk("ign_busy2", 32'(busy2), 32'd0);
      @(posedge clk); #1;
      chk("ign_done3", 32'(done2), 32'd0);
      chk("ign_busy3", 32'(busy2), 32'd0);
      @(posedge clk); #1;
      chk("b2b_busy", 32'(busy2), 32'd1);
      start2 = 1'b0;
      @(posedge clk); #1;
      chk("b2b_done0", 32'(done2), 32'd0);
      @(posedge clk); #1;
      model(2, 32'h8001, 32'h0002, 1'b1, 1'b1, er, ec, ev, ez);
      chk("b2b_done", 32'(done2), 32'd1);
      chk("b2b_res", {16'h0, res2}, er);
      chk("b2b_c", 32'(c2), 32'(ec));
      chk("b2b_v", 32'(v2), 32'(ev));
      @(posedge clk); #1;
      chk("b2b_done_end", 32'(done2), 32'd0);

      // Asynchronous reset in the middle of an operation
      op_a = 32'h01FF00FF; op_b = 32'h00010001; sub = 1'b0; cin_in = 1'b0;
      start1 = 1'b1; start2 = 1'b1; start4 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0; start2 = 1'b0; start4 = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("midrst_hold_done", {29'h0, done1, done2, done4}, 32'h0);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_nodone", {29'h0, done1, done2, done4}, 32'h0);
      run_op(32'h7FFF7FFF, 32'h00010001, 1'b0, 1'b0);

      // Random operations
      for (int i = 0; i < 30; i++) begin
         ra = $urandom; rb = $urandom;
         case ($urandom_range(0, 3))
            0: rb = ~ra;
            1: rb = 32'h0 - ra;
            2: ra = {ra[31], 31'h7FFFFFFF};
            default: ;
         endcase
         rs = 1'($urandom_range(0, 1));
         rc = 1'($urandom_range(0, 1));
         run_op(ra, rb, rs, rc);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
